rot_key_ctrl: RTL

ROT_KEY_CTRL -- requirements
Module: rot_key_ctrl

---
 rtl/rot_key_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rot_key_ctrl.sv
// rtl/rot_key_ctrl.sv - keyboard-driven piece rotation controller with collision handshake and auto-repeat
// Requests a CW/CCW rotation, commits it on ack, drops it on nak, and auto-repeats while the key is held.
module rot_key_ctrl #(
  parameter int          NUM_ROT       = 4,
  parameter int          ROT_W         = $clog2(NUM_ROT),
  parameter logic [15:0] KEY_CW        = 16'h001A,
  parameter logic [15:0] KEY_CCW       = 16'h0008,
  parameter int          REPEAT_DELAY  = 20,
  parameter int          REPEAT_PERIOD = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             spawn,
  input  logic [15:0]      keycode,
  input  logic             rot_ack,
  input  logic             rot_nak,
  output logic             rot_req,
  output logic [ROT_W-1:0] rot_next,
  output logic [ROT_W-1:0] shape_rot,
  output logic             rot_busy
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(NUM_ROT - 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ROT_W-1:0]   shape_q, shape_d;
  logic [ROT_W-1:0]   next_q, next_d;
  logic               ccw_q, ccw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rep_q, rep_d;
  logic               req_q;
  logic [15:0]        held_key;
  logic [CNT_W-1:0]   cnt_inc;

  function automatic logic [ROT_W-1:0] step(input logic [ROT_W-1:0] cur, input logic ccw);
    if (ccw) return (cur == '0) ? ROT_LAST : cur - ROT_W'(1);
    else     return (cur == ROT_LAST) ? '0 : cur + ROT_W'(1);
  endfunction

  assign held_key = ccw_q ? KEY_CCW : KEY_CW;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    shape_d = shape_q;
    next_d  = next_q;
    ccw_d   = ccw_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        rep_d = 1'b0;
        // CW is tested first so equal keycodes resolve as clockwise.
        if (keycode == KEY_CW) begin
          ccw_d   = 1'b0;
          next_d  = step(shape_q, 1'b0);
          state_d = REQ;
        end else if (keycode == KEY_CCW) begin
          ccw_d   = 1'b1;
          next_d  = step(shape_q, 1'b1);
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = '0;
        if (rot_nak) begin
          state_d = HOLD;
        end else if (rot_ack) begin
          shape_d = next_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (keycode == 16'h0000) begin
          state_d = IDLE;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else if (keycode == held_key && REPEAT_DELAY > 0) begin
          if (cnt_inc == (rep_q ? PERIOD_C : DELAY_C)) begin
            state_d = REQ;
            cnt_d   = '0;
            rep_d   = 1'b1;
            next_d  = step(shape_q, ccw_q);
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (spawn) begin
      state_d = IDLE;
      shape_d = '0;
      next_d  = '0;
      cnt_d   = '0;
      rep_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      shape_q <= '0;
      next_q  <= '0;
      ccw_q   <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shape_q <= shape_d;
      next_q  <= next_d;
      ccw_q   <= ccw_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      req_q   <= (state_d == REQ);
    end
  end

  assign rot_req   = req_q;
  assign rot_next  = next_q;
  assign shape_rot = shape_q;
  assign rot_busy  = (state_q != IDLE);

endmodule
